// File: rtl/ahb_lsu_master.sv
// Single-outstanding AHB-Lite manager that turns processor load/store requests into bus transfers.
// Define LSU_MISALIGN_TRAP_EN to fail misaligned requests instead of aligning them down.
module ahb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        proc_req_valid,
    output logic        proc_req_ready,
    input  logic        proc_write,
    input  logic        proc_unsigned,
    input  logic [1:0]  proc_size,
    input  logic [31:0] proc_addr,
    input  logic [31:0] proc_wdata,
    output logic        proc_rsp_valid,
    output logic        proc_rsp_err,
    output logic [31:0] proc_rdata,
    output logic [31:0] HADDR,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WaitW = (CntW > 10) ? CntW : 10;

    typedef enum logic [2:0] {StIdle, StAddr, StData, StErr, StRsp} state_e;

    state_e           state_q, state_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [2:0]       hsize_q, hsize_d;
    logic             hwrite_q, hwrite_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic [31:0]      store_q, store_d;
    logic             unsigned_q, unsigned_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WaitW-1:0] wait_q, wait_d;

    logic             trap;
    logic [31:0]      aligned_addr;
    logic [31:0]      repl_wdata;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic [WaitW-1:0] wait_inc;
    logic             timeout;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = (proc_size == 2'b01 && proc_addr[0]) ||
                  (proc_size == 2'b10 && proc_addr[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    assign wait_inc = wait_q + 1'b1;
    assign timeout  = !HREADY && (wait_inc == WaitW'(TIMEOUT_CYCLES));

    always_comb begin
        aligned_addr = proc_addr;
        repl_wdata   = proc_wdata;
        unique case (proc_size)
            2'b00: repl_wdata = {4{proc_wdata[7:0]}};
            2'b01: begin
                repl_wdata   = {2{proc_wdata[15:0]}};
                aligned_addr = {proc_addr[31:1], 1'b0};
            end
            2'b10: aligned_addr = {proc_addr[31:2], 2'b00};
            default: ;
        endcase
    end

    // Lane select and extension use the registered address phase of the current transfer.
    always_comb begin
        unique case (haddr_q[1:0])
            2'd0: ld_byte = HRDATA[7:0];
            2'd1: ld_byte = HRDATA[15:8];
            2'd2: ld_byte = HRDATA[23:16];
            2'd3: ld_byte = HRDATA[31:24];
            default: ld_byte = HRDATA[7:0];
        endcase
        ld_half = haddr_q[1] ? HRDATA[31:16] : HRDATA[15:0];
        case (hsize_q)
            3'b000:  ld_data = unsigned_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = unsigned_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = HRDATA;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        store_d     = store_q;
        unsigned_d  = unsigned_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = '0;
        wait_d      = wait_q;
        unique case (state_q)
            StIdle: begin
                wait_d = '0;
                if (proc_req_valid) begin
                    if (proc_size == 2'b11 || trap) begin
                        state_d     = StRsp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = StAddr;
                        haddr_d    = aligned_addr;
                        hsize_d    = {1'b0, proc_size};
                        hwrite_d   = proc_write;
                        htrans_d   = 2'b10;
                        store_d    = proc_write ? repl_wdata : 32'b0;
                        unsigned_d = proc_unsigned;
                    end
                end
            end
            StAddr: begin
                if (HREADY) begin
                    state_d  = StData;
                    htrans_d = 2'b00;
                    hwdata_d = store_q;
                    wait_d   = '0;
                end else if (timeout) begin
                    state_d     = StRsp;
                    htrans_d    = 2'b00;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StData: begin
                if (HREADY) begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rdata_d     = (!HRESP && !hwrite_q) ? ld_data : 32'b0;
                    wait_d      = '0;
                end else if (timeout) begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_inc;
                    if (HRESP) begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                if (HREADY || timeout) begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StRsp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StIdle;
            haddr_q     <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= 2'b00;
            hwdata_q    <= '0;
            store_q     <= '0;
            unsigned_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            store_q     <= store_d;
            unsigned_q  <= unsigned_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            wait_q      <= wait_d;
        end
    end

    assign proc_req_ready = (state_q == StIdle);
    assign proc_rsp_valid = rsp_valid_q;
    assign proc_rsp_err   = rsp_err_q;
    assign proc_rdata     = rdata_q;
    assign HADDR          = haddr_q;
    assign HSIZE          = hsize_q;
    assign HWRITE         = hwrite_q;
    assign HTRANS         = htrans_q;
    assign HWDATA         = hwdata_q;

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Directed bench for ahb_lsu_master: vector table plus error, timeout and reset sequences.
module tb_ahb_lsu_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        proc_req_valid;
    logic        proc_req_ready;
    logic        proc_write;
    logic        proc_unsigned;
    logic [1:0]  proc_size;
    logic [31:0] proc_addr;
    logic [31:0] proc_wdata;
    logic        proc_rsp_valid;
    logic        proc_rsp_err;
    logic [31:0] proc_rdata;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        wr;
        logic        uns;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre;
        logic [31:0] mem_word;
        logic        bus;
        logic [31:0] exp_haddr;
        logic [2:0]  exp_hsize;
        logic [31:0] exp_hwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVec = 13;
    vec_t vecs [NVec];

    ahb_lsu_master #(.TIMEOUT_CYCLES(1024)) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .proc_req_valid (proc_req_valid),
        .proc_req_ready (proc_req_ready),
        .proc_write     (proc_write),
        .proc_unsigned  (proc_unsigned),
        .proc_size      (proc_size),
        .proc_addr      (proc_addr),
        .proc_wdata     (proc_wdata),
        .proc_rsp_valid (proc_rsp_valid),
        .proc_rsp_err   (proc_rsp_err),
        .proc_rdata     (proc_rdata),
        .HADDR          (HADDR),
        .HSIZE          (HSIZE),
        .HWRITE         (HWRITE),
        .HTRANS         (HTRANS),
        .HWDATA         (HWDATA),
        .HRDATA         (HRDATA),
        .HREADY         (HREADY),
        .HRESP          (HRESP)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic wr, input logic uns, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        proc_req_valid = 1'b1;
        proc_write     = wr;
        proc_unsigned  = uns;
        proc_size      = size;
        proc_addr      = addr;
        proc_wdata     = wdata;
    endtask

    // Zero-wait transfer; the bench subordinate reads/writes mem at the observed address.
    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] cap_addr;
        logic [2:0]  cap_size;
        logic [3:0]  be;
        @(negedge HCLK);
        if (v.pre) mem[v.addr[9:2]] = v.mem_word;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        set_req(v.wr, v.uns, v.size, v.addr, v.wdata);
        chk({nm, ".ready_idle"}, {31'b0, proc_req_ready}, 32'd1);
        @(negedge HCLK);
        if (v.bus) begin
            chk({nm, ".htrans_nonseq"}, {30'b0, HTRANS}, 32'h2);
            chk({nm, ".haddr"}, HADDR, v.exp_haddr);
            chk({nm, ".hsize"}, {29'b0, HSIZE}, {29'b0, v.exp_hsize});
            chk({nm, ".hwrite"}, {31'b0, HWRITE}, {31'b0, v.wr});
            cap_addr = HADDR;
            cap_size = HSIZE;
            HRDATA   = mem[cap_addr[9:2]];
            @(negedge HCLK);
            chk({nm, ".htrans_idle"}, {30'b0, HTRANS}, 32'h0);
            if (v.wr) begin
                chk({nm, ".hwdata"}, HWDATA, v.exp_hwdata);
                case (cap_size)
                    3'b000:  be = 4'b0001 << cap_addr[1:0];
                    3'b001:  be = cap_addr[1] ? 4'b1100 : 4'b0011;
                    default: be = 4'b1111;
                endcase
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[cap_addr[9:2]][8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
            @(negedge HCLK);
        end else begin
            chk({nm, ".htrans_nobus"}, {30'b0, HTRANS}, 32'h0);
        end
        chk({nm, ".rsp_valid"}, {31'b0, proc_rsp_valid}, 32'd1);
        chk({nm, ".rsp_err"}, {31'b0, proc_rsp_err}, {31'b0, v.exp_err});
        chk({nm, ".rdata"}, proc_rdata, v.exp_rdata);
        chk({nm, ".ready_rsp"}, {31'b0, proc_req_ready}, 32'd0);
        proc_req_valid = 1'b0;
        @(negedge HCLK);
        chk({nm, ".rsp_pulse"}, {31'b0, proc_rsp_valid}, 32'd0);
        chk({nm, ".ready_back"}, {31'b0, proc_req_ready}, 32'd1);
    endtask

    initial begin
        logic early;
        logic seen;

        //          wr    uns   size   addr          wdata         pre   mem_word      bus
        //          haddr         hsize   hwdata        rdata         err
        vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1,
                     32'h0000_0100, 3'b010, 32'h0,        32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0103, 32'h0,        1'b1, 32'h8011_2233, 1'b1,
                     32'h0000_0103, 3'b000, 32'h0,        32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0103, 32'h0,        1'b1, 32'h8011_2233, 1'b1,
                     32'h0000_0103, 3'b000, 32'h0,        32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0102, 32'h0,        1'b1, 32'h8011_2233, 1'b1,
                     32'h0000_0102, 3'b001, 32'h0,        32'hFFFF_8011, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0100, 32'h0,        1'b1, 32'h8011_2233, 1'b1,
                     32'h0000_0100, 3'b001, 32'h0,        32'h0000_2233, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0201, 32'h0000_005A, 1'b1, 32'h1122_3344, 1'b1,
                     32'h0000_0201, 3'b000, 32'h5A5A_5A5A, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0000_ABCD, 1'b0, 32'h0,        1'b1,
                     32'h0000_0202, 3'b001, 32'hABCD_ABCD, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'h0,        1'b0, 32'h0,         1'b1,
                     32'h0000_0200, 3'b010, 32'h0,        32'hABCD_5A44, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0204, 32'h1234_5678, 1'b1, 32'h0,        1'b1,
                     32'h0000_0204, 3'b010, 32'h1234_5678, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0,        1'b0, 32'h0,         1'b0,
                     32'h0,        3'b000, 32'h0,        32'h0,         1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 32'h0000_0102, 32'h0,        1'b1, 32'h8011_2233, 1'b1,
                     32'h0000_0102, 3'b000, 32'h0,        32'h0000_0011, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = '{1'b0, 1'b0, 2'b10, 32'h0000_0101, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0,
                     32'h0,        3'b000, 32'h0,        32'h0,         1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'b01, 32'h0000_0103, 32'h0,        1'b1, 32'h8011_2233, 1'b0,
                     32'h0,        3'b000, 32'h0,        32'h0,         1'b1};
`else
        vecs[10] = '{1'b0, 1'b0, 2'b10, 32'h0000_0101, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1,
                     32'h0000_0100, 3'b010, 32'h0,        32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'b01, 32'h0000_0103, 32'h0,        1'b1, 32'h8011_2233, 1'b1,
                     32'h0000_0102, 3'b001, 32'h0,        32'hFFFF_8011, 1'b0};
`endif

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        HRESET = 1'b1;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        proc_req_valid = 1'b0;
        repeat (2) @(negedge HCLK);
        chk("rst.htrans", {30'b0, HTRANS}, 32'h0);
        chk("rst.haddr", HADDR, 32'h0);
        chk("rst.hsize", {29'b0, HSIZE}, 32'h0);
        chk("rst.hwrite", {31'b0, HWRITE}, 32'h0);
        chk("rst.hwdata", HWDATA, 32'h0);
        chk("rst.rsp_valid", {31'b0, proc_rsp_valid}, 32'h0);
        chk("rst.rsp_err", {31'b0, proc_rsp_err}, 32'h0);
        chk("rst.rdata", proc_rdata, 32'h0);
        chk("rst.ready", {31'b0, proc_req_ready}, 32'd1);
        HRESET = 1'b0;

        for (int i = 0; i < NVec; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Address-phase wait states, then a two-cycle ERROR response.
        @(negedge HCLK);
        set_req(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        HRDATA = 32'hFFFF_FFFF;
        @(negedge HCLK);
        proc_req_valid = 1'b0;
        HREADY = 1'b0;
        chk("err.nonseq", {30'b0, HTRANS}, 32'h2);
        @(negedge HCLK);
        chk("err.hold_htrans", {30'b0, HTRANS}, 32'h2);
        chk("err.hold_haddr", HADDR, 32'h0000_0100);
        @(negedge HCLK);
        chk("err.hold_htrans2", {30'b0, HTRANS}, 32'h2);
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("err.data_idle", {30'b0, HTRANS}, 32'h0);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        @(negedge HCLK);
        chk("err.errcyc_idle", {30'b0, HTRANS}, 32'h0);
        chk("err.errcyc_norsp", {31'b0, proc_rsp_valid}, 32'h0);
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESP = 1'b0;
        chk("err.rsp_valid", {31'b0, proc_rsp_valid}, 32'd1);
        chk("err.rsp_err", {31'b0, proc_rsp_err}, 32'd1);
        chk("err.rdata", proc_rdata, 32'h0);
        @(negedge HCLK);
        chk("err.pulse", {31'b0, proc_rsp_valid}, 32'h0);

        // Data phase stalled for 1024 cycles.
        set_req(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        @(negedge HCLK);
        proc_req_valid = 1'b0;
        chk("to.nonseq", {30'b0, HTRANS}, 32'h2);
        @(negedge HCLK);
        HREADY = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 1023; k++) begin
            @(negedge HCLK);
            if (proc_rsp_valid !== 1'b0) early = 1'b1;
        end
        chk("to.no_early_rsp", {31'b0, early}, 32'h0);
        @(negedge HCLK);
        chk("to.rsp_valid", {31'b0, proc_rsp_valid}, 32'd1);
        chk("to.rsp_err", {31'b0, proc_rsp_err}, 32'd1);
        chk("to.htrans", {30'b0, HTRANS}, 32'h0);
        HREADY = 1'b1;
        run_vec(vecs[0], "to.next");

        // Reset during the address phase.
        @(negedge HCLK);
        set_req(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        @(negedge HCLK);
        proc_req_valid = 1'b0;
        chk("rstmid.nonseq", {30'b0, HTRANS}, 32'h2);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        chk("rstmid.htrans", {30'b0, HTRANS}, 32'h0);
        chk("rstmid.ready", {31'b0, proc_req_ready}, 32'd1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge HCLK);
            if (proc_rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("rstmid.no_rsp", {31'b0, seen}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
